// File: rtl/insertion_sort_engine_pkg.sv
// insertion_sort_engine_pkg: state encodings and constants shared by the sort blocks
package insertion_sort_engine_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_C_CHECK, S_D_INIT, S_RD1, S_RD2, S_CMP, S_WR1, S_WR2, S_INCR, S_DONE
  } state_e;
  localparam int MEM_LAT = 1;
endpackage

// File: rtl/insertion_sort_engine_if.sv
// insertion_sort_engine_if: control handshake and data-memory port of the sort engine
interface insertion_sort_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                  c_s_go;
  logic [ADDR_W:0]       len;
  logic                  busy;
  logic                  done;
  logic [2*ADDR_W-1:0]   swap_cnt;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  modport master (
    output c_s_go, len, mem_rdata,
    input  busy, done, swap_cnt, mem_addr, mem_rd, mem_wr, mem_wdata
  );
  modport slave (
    input  c_s_go, len, mem_rdata,
    output busy, done, swap_cnt, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/insertion_sort_engine_cmp.sv
// sort_cmp: out-of-order test between two neighbouring words; equal words never swap
module sort_cmp #(
  parameter int DATA_W  = 8,
  parameter int DESCEND = 0,
  parameter int SIGNED  = 0
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              ooo_o
);
  logic gt, lt;
  assign gt    = (SIGNED != 0) ? ($signed(a_i) > $signed(b_i)) : (a_i > b_i);
  assign lt    = (SIGNED != 0) ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
  assign ooo_o = (DESCEND != 0) ? lt : gt;
endmodule

// File: rtl/insertion_sort_engine.sv
// insertion_sort_engine: in-place insertion sort of the first len words of a single-port memory
module insertion_sort_engine
  import insertion_sort_engine_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DESCEND = 0,
  parameter int SIGNED  = 0
) (
  input  logic                    c_clk,
  input  logic                    c_s_rst,
  insertion_sort_engine_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int IW    = ADDR_W + 1;
  state_e              state_q, state_d;
  logic [ADDR_W:0]     c_q, c_d, d_q, d_d, len_q, len_d;
  logic [DATA_W-1:0]   t1_q, t1_d, t2_q, t2_d, wdata_q, wdata_d;
  logic [2*ADDR_W-1:0] swap_q, swap_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d, wr_q, wr_d, ooo;
  sort_cmp #(.DATA_W(DATA_W), .DESCEND(DESCEND), .SIGNED(SIGNED)) u_cmp (
    .a_i   (t1_q),
    .b_i   (bus.mem_rdata),
    .ooo_o (ooo)
  );
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    len_d   = len_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    swap_d  = swap_q;
    case (state_q)
      S_IDLE: if (bus.c_s_go) begin
        state_d = S_C_CHECK;
        len_d   = (bus.len > IW'(DEPTH)) ? IW'(DEPTH) : bus.len;
        c_d     = IW'(1);
        swap_d  = '0;
      end
      S_C_CHECK: begin
        state_d = (c_q < len_q) ? S_D_INIT : S_DONE;
        d_d     = c_q;
      end
      S_D_INIT: state_d = S_RD1;
      S_RD1:    state_d = S_RD2;
      S_RD2: begin
        state_d = S_CMP;
        t1_d    = bus.mem_rdata;
      end
      S_CMP: begin
        state_d = ooo ? S_WR1 : S_INCR;
        t2_d    = bus.mem_rdata;
      end
      S_WR1:    state_d = S_WR2;
      S_WR2: begin
        state_d = (d_q == IW'(1)) ? S_INCR : S_RD1;
        d_d     = d_q - IW'(1);
        swap_d  = swap_q + 1'b1;
      end
      S_INCR: begin
        state_d = S_C_CHECK;
        c_d     = c_q + IW'(1);
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // strobes/address are registered, so they are derived from the state being entered
    rd_d    = (state_d == S_RD1) || (state_d == S_RD2);
    wr_d    = (state_d == S_WR1) || (state_d == S_WR2);
    addr_d  = (state_d == S_RD1 || state_d == S_WR1) ? ADDR_W'(d_d - IW'(1)) :
              (rd_d || wr_d) ? ADDR_W'(d_d) : addr_q;
    wdata_d = (state_d == S_WR1) ? t2_d : (state_d == S_WR2) ? t1_q : wdata_q;
  end
  always_ff @(posedge c_clk) begin
    if (c_s_rst) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      len_q   <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      swap_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      len_q   <= len_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      swap_q  <= swap_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.swap_cnt  = swap_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_insertion_sort_engine.sv
// tb_insertion_sort_engine: table-driven sort runs against a 16x8 memory model with a result scoreboard
module tb_insertion_sort_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  insertion_sort_engine_if #(.DATA_W(8), .ADDR_W(4)) b0 ();
  insertion_sort_engine_if #(.DATA_W(8), .ADDR_W(4)) b1 ();
  insertion_sort_engine #(.DATA_W(8), .ADDR_W(4), .DESCEND(0), .SIGNED(0)) dut0 (
    .c_clk(clk), .c_s_rst(rst), .bus(b0)
  );
  insertion_sort_engine #(.DATA_W(8), .ADDR_W(4), .DESCEND(1), .SIGNED(1)) dut1 (
    .c_clk(clk), .c_s_rst(rst), .bus(b1)
  );
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  always @(posedge clk) begin
    if (b0.mem_wr) mem0[b0.mem_addr] = b0.mem_wdata;
    if (b0.mem_rd) b0.mem_rdata <= mem0[b0.mem_addr];
    if (b1.mem_wr) mem1[b1.mem_addr] = b1.mem_wdata;
    if (b1.mem_rd) b1.mem_rdata <= mem1[b1.mem_addr];
  end
  typedef struct { bit u; logic [4:0] len; int cyc; logic [7:0] d [16]; } vec_t;
  typedef struct { logic [7:0] d [16]; int swaps; int cyc; } exp_t;
  vec_t tv [$];
  exp_t sb [$];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic bit ooo_m(bit u, logic [7:0] a, logic [7:0] b);
    return u ? ($signed(a) < $signed(b)) : (a > b);
  endfunction
  function automatic exp_t model(bit u, logic [4:0] len, logic [7:0] d [16], int cyc);
    exp_t e;
    logic [7:0] t;
    int n;
    e.d = d;
    e.swaps = 0;
    e.cyc = cyc;
    n = (len > 16) ? 16 : int'(len);
    for (int i = 1; i < n; i++)
      for (int j = i; j > 0 && ooo_m(u, e.d[j-1], e.d[j]); j--) begin
        t = e.d[j]; e.d[j] = e.d[j-1]; e.d[j-1] = t;
        e.swaps++;
      end
    return e;
  endfunction
  function automatic vec_t mk(bit u, logic [4:0] len, int cyc, logic [7:0] q [$]);
    vec_t v;
    v.u = u; v.len = len; v.cyc = cyc;
    for (int i = 0; i < 16; i++) v.d[i] = (i < q.size()) ? q[i] : 8'($urandom);
    return v;
  endfunction
  task automatic load(input bit u, input logic [7:0] d [16]);
    for (int i = 0; i < 16; i++) if (u) mem1[i] = d[i]; else mem0[i] = d[i];
  endtask
  task automatic run(input bit u, input logic [4:0] l, input int cyc_exp,
                     input int glitch_at, input int rst_at);
    exp_t e;
    logic [7:0] snap [16];
    bit dn, bz, rd, wr, rd_seen, wr_seen, both, blow;
    int cyc, n;
    for (int i = 0; i < 16; i++) snap[i] = u ? mem1[i] : mem0[i];
    sb.push_back(model(u, l, snap, cyc_exp));
    rd_seen = 0; wr_seen = 0; both = 0; blow = 0; cyc = 0; dn = 0;
    n = (l > 16) ? 16 : int'(l);
    @(posedge clk); #1;
    if (u) begin b1.c_s_go = 1'b1; b1.len = l; end
    else   begin b0.c_s_go = 1'b1; b0.len = l; end
    while (!dn && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      b0.c_s_go = 1'b0; b1.c_s_go = 1'b0;
      dn = u ? b1.done : b0.done;
      bz = u ? b1.busy : b0.busy;
      rd = u ? b1.mem_rd : b0.mem_rd;
      wr = u ? b1.mem_wr : b0.mem_wr;
      if (cyc == rst_at) break;
      if (cyc == glitch_at) begin
        if (u) b1.c_s_go = 1'b1; else b0.c_s_go = 1'b1;
        b0.len = 5'd0; b1.len = 5'd0;
      end
      rd_seen |= rd; wr_seen |= wr; both |= rd & wr; blow |= !bz;
    end
    if (cyc == rst_at) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_busy", int'(b0.busy), 0);
      chk("rst_rd", int'(b0.mem_rd), 0);
      chk("rst_wr", int'(b0.mem_wr), 0);
      chk("rst_swap", int'(b0.swap_cnt), 0);
      void'(sb.pop_front());
      return;
    end
    chk("done_seen", int'(dn), 1);
    e = sb.pop_front();
    if (e.cyc >= 0) chk("latency", cyc, e.cyc);
    chk("swap_cnt", int'(u ? b1.swap_cnt : b0.swap_cnt), e.swaps);
    chk("rd_activity", int'(rd_seen), int'(n > 1));
    chk("wr_activity", int'(wr_seen), int'(e.swaps > 0));
    chk("rd_wr_both", int'(both), 0);
    chk("busy_gap", int'(blow), 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mem[%0d]", i), int'(u ? mem1[i] : mem0[i]), int'(e.d[i]));
    @(posedge clk); #1;
    chk("done_one_cycle", int'(u ? b1.done : b0.done), 0);
    chk("busy_after", int'(u ? b1.busy : b0.busy), 0);
  endtask
  initial begin
    logic [7:0] q [$];
    logic [7:0] d [16];
    logic [7:0] sexp [5];
    b0.c_s_go = 1'b0; b0.len = '0;
    b1.c_s_go = 1'b0; b1.len = '0;
    for (int i = 0; i < 16; i++) begin mem0[i] = '0; mem1[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(b0.busy), 0);
    chk("reset_done", int'(b0.done), 0);
    chk("reset_strobes", int'({b0.mem_rd, b0.mem_wr}), 0);
    chk("reset_addr", int'(b0.mem_addr), 0);
    chk("reset_wdata", int'(b0.mem_wdata), 0);
    chk("reset_swap", int'(b0.swap_cnt), 0);
    rst = 1'b0;
    q = '{8'd1, 8'd2, 8'd3, 8'd4};              tv.push_back(mk(0, 5'd4, 20, q));
    q = '{8'd4, 8'd3, 8'd2, 8'd1};              tv.push_back(mk(0, 5'd4, -1, q));
    q = '{8'd9, 8'd8, 8'd7};                    tv.push_back(mk(0, 5'd0, 2, q));
    q = '{8'd9, 8'd8, 8'd7};                    tv.push_back(mk(0, 5'd1, 2, q));
    q = '{8'hFD, 8'd5, 8'd0, 8'h80, 8'h7F};     tv.push_back(mk(1, 5'd5, -1, q));
    q = '{8'd2, 8'd2};                          tv.push_back(mk(1, 5'd2, 8, q));
    q = '{8'd5, 8'd1, 8'd5, 8'd0, 8'd5, 8'd3};  tv.push_back(mk(0, 5'd6, -1, q));
    q.delete();                                 tv.push_back(mk(0, 5'd16, -1, q));
    q.delete();                                 tv.push_back(mk(0, 5'd20, -1, q));
    q.delete();                                 tv.push_back(mk(1, 5'd16, -1, q));
    foreach (tv[k]) begin
      load(tv[k].u, tv[k].d);
      run(tv[k].u, tv[k].len, tv[k].cyc, -1, -1);
    end
    // go pulsed mid-run with len=0 must not restart or shorten the sort
    q = '{8'd1, 8'd2, 8'd3, 8'd4};
    d = mk(0, 5'd4, 20, q).d;
    load(0, d);
    run(0, 5'd4, 20, 5, -1);
    q = '{8'hFD, 8'd5, 8'd0, 8'h80, 8'h7F, 8'd0};
    d = mk(1, 5'd5, -1, q).d;
    load(1, d);
    run(1, 5'd5, -1, -1, -1);
    sexp = '{8'h7F, 8'd5, 8'd0, 8'hFD, 8'h80};
    for (int i = 0; i < 5; i++) chk($sformatf("signed_desc[%0d]", i), int'(mem1[i]), int'(sexp[i]));
    chk("signed_desc_tail", int'(mem1[5]), 0);
    // abort mid-run, then a fresh run must finish sorting whatever was left
    q.delete();
    d = mk(0, 5'd16, -1, q).d;
    load(0, d);
    run(0, 5'd16, -1, -1, 40);
    run(0, 5'd16, -1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
